// File: rtl/morse_keyer.sv
// morse_keyer: plays a stored dot/dash/gap message as timed tone-enable keying.
// Optional feature macro: MORSE_KEYER_REPEAT_EN (looping playback while i_repeat is high).
module morse_keyer #(
    parameter real         FREQUENCY = 60_000_000.0,
    parameter real         DOT_TIME  = 0.06,
    parameter int unsigned MSG_DEPTH = 64
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_msg_we,
    input  logic [$clog2(MSG_DEPTH)-1:0] i_msg_addr,
    input  logic [1:0]                   i_msg_data,
    input  logic [$clog2(MSG_DEPTH):0]   i_msg_len,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic                         i_repeat,
    output logic                         o_key,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [$clog2(MSG_DEPTH)-1:0] o_sym_idx
);

    localparam int unsigned UNIT_CLOCKS = $rtoi(FREQUENCY * DOT_TIME + 0.5);
    localparam int unsigned AW          = $clog2(MSG_DEPTH);
    localparam int unsigned UW          = $clog2(UNIT_CLOCKS);
    localparam int unsigned NW          = 3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MARK, S_SPACE} state_t;

    state_t          r_state, w_state_n;
    logic [UW-1:0]   r_cnt, w_cnt_n;
    logic [NW-1:0]   r_units, w_units_n;
    logic [AW-1:0]   r_sym_idx, w_idx_n;
    logic [AW:0]     r_len, w_len_n;
    logic            r_key, r_busy, r_done;
    logic            w_key_n, w_busy_n, w_done_n;
    logic [1:0]      r_mem [MSG_DEPTH];
    logic [1:0]      w_code;
    logic            w_unit_end, w_last_unit, w_more, w_repeat;

`ifdef MORSE_KEYER_REPEAT_EN
    assign w_repeat = i_repeat;
`else
    logic w_unused_repeat;
    assign w_repeat        = 1'b0;
    assign w_unused_repeat = i_repeat;
`endif

    assign w_code      = r_mem[r_sym_idx];
    assign w_unit_end  = (r_cnt == UW'(UNIT_CLOCKS - 1));
    assign w_last_unit = w_unit_end && (r_units == NW'(1));
    assign w_more      = ((AW+1)'(r_sym_idx) + (AW+1)'(1)) < r_len;

    // Message memory, writable at any time, not reset.
    always_ff @(posedge i_clk) begin
        if (i_msg_we) r_mem[i_msg_addr] <= i_msg_data;
    end

    // State, timing counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_units   <= '0;
            r_sym_idx <= '0;
            r_len     <= '0;
            r_key     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_units   <= w_units_n;
            r_sym_idx <= w_idx_n;
            r_len     <= w_len_n;
            r_key     <= w_key_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
        end
    end

    // Next-state logic: symbol decode, unit timing, stop/end-of-message handling.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_units_n = r_units;
        w_idx_n   = r_sym_idx;
        w_len_n   = r_len;
        w_done_n  = 1'b0;
        if (r_state != S_IDLE && i_stop) begin
            w_state_n = S_IDLE;
            w_idx_n   = '0;
            w_done_n  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_stop) begin
                        if (i_msg_len == '0) begin
                            w_done_n = 1'b1;
                        end else begin
                            w_len_n   = i_msg_len;
                            w_idx_n   = '0;
                            w_state_n = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    w_cnt_n = '0;
                    case (w_code)
                        2'd0: begin w_state_n = S_MARK;  w_units_n = NW'(1); end
                        2'd1: begin w_state_n = S_MARK;  w_units_n = NW'(3); end
                        2'd2: begin w_state_n = S_SPACE; w_units_n = NW'(2); end
                        default: begin w_state_n = S_SPACE; w_units_n = NW'(6); end
                    endcase
                end
                S_MARK: begin
                    if (w_last_unit) begin
                        w_cnt_n   = '0;
                        w_units_n = NW'(1);
                        w_state_n = S_SPACE;
                    end else if (w_unit_end) begin
                        w_cnt_n   = '0;
                        w_units_n = r_units - NW'(1);
                    end else begin
                        w_cnt_n = r_cnt + UW'(1);
                    end
                end
                S_SPACE: begin
                    if (w_last_unit) begin
                        w_cnt_n = '0;
                        if (w_more) begin
                            w_idx_n   = r_sym_idx + AW'(1);
                            w_state_n = S_LOAD;
                        end else if (w_repeat) begin
                            w_idx_n   = '0;
                            w_state_n = S_LOAD;
                        end else begin
                            w_idx_n   = '0;
                            w_done_n  = 1'b1;
                            w_state_n = S_IDLE;
                        end
                    end else if (w_unit_end) begin
                        w_cnt_n   = '0;
                        w_units_n = r_units - NW'(1);
                    end else begin
                        w_cnt_n = r_cnt + UW'(1);
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
        w_key_n  = (w_state_n == S_MARK);
        w_busy_n = (w_state_n != S_IDLE);
    end

    assign o_key     = r_key;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_sym_idx = r_sym_idx;

endmodule
